// File: rtl/key_event_if.sv
// key_event_if: key level in, decoded event pulses and press counter out
interface key_event_if #(parameter int CNT_W = 8);
  logic             key_pressed;
  logic             press_pulse;
  logic             release_pulse;
  logic             short_press;
  logic             long_press;
  logic             double_press;
  logic [CNT_W-1:0] press_count;
  logic [2:0]       state_o;
  modport master (
    output key_pressed,
    input  press_pulse, release_pulse, short_press, long_press, double_press, press_count, state_o
  );
  modport slave (
    input  key_pressed,
    output press_pulse, release_pulse, short_press, long_press, double_press, press_count, state_o
  );
endinterface

// File: rtl/key_event_decoder.sv
// key_event_decoder: turns a debounced key level into registered press/release/short/long/double pulses
module key_event_decoder #(
  parameter int LONG_TIME  = 1000,
  parameter int DOUBLE_GAP = 300,
  parameter int CNT_W      = 8
) (
  input logic      clk,
  input logic      rst_n,
  key_event_if.slave bus
);
  localparam int MAX_T = (LONG_TIME > DOUBLE_GAP) ? LONG_TIME : DOUBLE_GAP;
  localparam int TW    = $clog2(MAX_T) + 1;
  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
  } state_t;
  state_t           state, state_n;
  logic [TW-1:0]    timer;
  logic             key_q, rise, fall;
  logic             pp, rp, sp, lp, dp;
  logic [4:0]       ev_q;
  logic [CNT_W-1:0] cnt_q;
  assign rise = bus.key_pressed & ~key_q;
  assign fall = ~bus.key_pressed & key_q;
  assign {bus.press_pulse, bus.release_pulse, bus.short_press, bus.long_press, bus.double_press} = ev_q;
  assign bus.press_count = cnt_q;
  assign bus.state_o     = state;
  // next state and event decode; an edge always beats a timer expiry in the same cycle
  always_comb begin
    state_n = state;
    pp = 1'b0;
    rp = 1'b0;
    sp = 1'b0;
    lp = 1'b0;
    dp = 1'b0;
    case (state)
      IDLE: if (rise) begin
        pp = 1'b1;
        state_n = PRESSED;
      end
      PRESSED: if (fall) begin
        rp = 1'b1;
        state_n = WAIT_SECOND;
      end else if (timer == TW'(LONG_TIME - 1)) begin
        lp = 1'b1;
        state_n = LONG_HELD;
      end
      LONG_HELD: if (fall) begin
        rp = 1'b1;
        state_n = IDLE;
      end
      WAIT_SECOND: if (rise) begin
        pp = 1'b1;
        state_n = SECOND_PRESSED;
      end else if (timer == TW'(DOUBLE_GAP - 1)) begin
        sp = 1'b1;
        state_n = IDLE;
      end
      SECOND_PRESSED: if (fall) begin
        rp = 1'b1;
        dp = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, edge history, phase timer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      key_q <= 1'b0;
      ev_q  <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_n;
      timer <= (state_n != state) ? '0 : timer + 1'b1;
      key_q <= bus.key_pressed;
      ev_q  <= {pp, rp, sp, lp, dp};
      cnt_q <= cnt_q + CNT_W'(pp);
    end
  end
endmodule
